// File: rtl/sprinkler_pkg.sv
// Shared types and defaults for the sprinkler zone sequencer.
// The HOLD state is only reachable when RAIN_SENSE_EN is defined.
package sprinkler_pkg;

  localparam int STATE_W            = 2;
  localparam int DEFAULT_DUR_W      = 8;
  localparam int DEFAULT_GAP_CYCLES = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/sprinkler_zone_sequencer_zone_decoder.sv
// Combinational zone index + enable to one-hot valve pattern.
// An index with no matching output (>= NUM_ZONES) decodes to all zeros.
module zone_decoder #(
  parameter int NUM_ZONES = 8
) (
  input  logic [$clog2(NUM_ZONES)-1:0] idx,
  input  logic                         en,
  output logic [NUM_ZONES-1:0]         onehot
);

  localparam int ZONE_W = $clog2(NUM_ZONES);

  // One comparator per output bit; at most one can match.
  for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_bit
    assign onehot[gi] = en && (idx == ZONE_W'(gi));
  end

endmodule

// File: rtl/sprinkler_zone_sequencer.sv
// Automatic sprinkler watering sequencer with break-before-make gaps and a
// manual single-zone mode. All outputs are registered.
// Optional feature macro: RAIN_SENSE_EN adds a 'rain' input and HOLD state.
module sprinkler_zone_sequencer
  import sprinkler_pkg::*;
#(
  parameter int NUM_ZONES  = 8,
  parameter int ZONE_W     = $clog2(NUM_ZONES),
  parameter int DUR_W      = DEFAULT_DUR_W,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 manual_mode,
  input  logic [ZONE_W-1:0]    manual_zone,
  input  logic                 cfg_we,
  input  logic [ZONE_W-1:0]    cfg_zone,
  input  logic [DUR_W-1:0]     cfg_dur,
  output logic [NUM_ZONES-1:0] valve,
  output logic [ZONE_W-1:0]    active_zone,
  output logic                 busy,
  output logic                 done
`ifdef RAIN_SENSE_EN
  ,
  input  logic                 rain
`endif
);

  localparam int                 GAP_W      = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0]   GAP_INIT   = GAP_W'(GAP_CYCLES);
  localparam logic [ZONE_W:0]    ZONE_LIMIT = (ZONE_W + 1)'(NUM_ZONES);

  state_t                state_reg, state_next;
  logic [ZONE_W-1:0]     zone_reg, zone_next;
  logic [DUR_W-1:0]      timer_reg, timer_next;
  logic [GAP_W-1:0]      gap_reg, gap_next;
  logic                  done_next;
  logic [DUR_W-1:0]      dur_table_reg [NUM_ZONES];

  logic [ZONE_W:0]       search_from;
  logic                  found;
  logic [ZONE_W-1:0]     found_idx;
  logic [DUR_W-1:0]      found_dur;

  logic                  manual_hit;
  logic                  idle_blocked;
  logic                  dec_en;
  logic [ZONE_W-1:0]     dec_idx;
  logic [NUM_ZONES-1:0]  dec_onehot;

`ifdef RAIN_SENSE_EN
  state_t                held_reg, held_next;
  assign idle_blocked = rain;
`else
  assign idle_blocked = 1'b0;
`endif

  // Duration table: written from config port, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ZONES; i++) dur_table_reg[i] <= '0;
    end else if (cfg_we && ({1'b0, cfg_zone} < ZONE_LIMIT)) begin
      dur_table_reg[cfg_zone] <= cfg_dur;
    end
  end

  // A fresh cycle searches from zone 0; after a gap, from the zone after the current one.
  assign search_from = (state_reg == ST_IDLE) ? '0 : ({1'b0, zone_reg} + (ZONE_W + 1)'(1));

  // Lowest zone at or above search_from with a non-zero duration (zero zones are skipped).
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if ((i >= int'(search_from)) && (dur_table_reg[i] != '0)) begin
        found     = 1'b1;
        found_idx = ZONE_W'(i);
      end
    end
    found_dur = dur_table_reg[found_idx];
  end

  // Next-state, counters and valve decode request.
  always_comb begin
    state_next = state_reg;
    zone_next  = zone_reg;
    timer_next = timer_reg;
    gap_next   = gap_reg;
    done_next  = 1'b0;
    manual_hit = 1'b0;
    dec_en     = 1'b0;
    dec_idx    = zone_reg;
`ifdef RAIN_SENSE_EN
    held_next  = held_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (en && !stop && !idle_blocked) begin
          if (manual_mode) begin
            manual_hit = 1'b1;
          end else if (start && found) begin
            // An all-zero table gives nothing to run, so start is a no-op.
            state_next = ST_RUN;
            zone_next  = found_idx;
            timer_next = found_dur;
          end
        end
      end

      ST_RUN: begin
        // timer counts valve-on cycles remaining including the current one.
        if (timer_reg <= DUR_W'(1)) begin
          state_next = ST_GAP;
          gap_next   = GAP_INIT;
        end else begin
          timer_next = timer_reg - DUR_W'(1);
        end
`ifdef RAIN_SENSE_EN
        // The on-cycle just finished still counts; the remainder resumes after HOLD.
        if (rain) begin
          held_next  = state_next;
          state_next = ST_HOLD;
        end
`endif
      end

      ST_GAP: begin
`ifdef RAIN_SENSE_EN
        if (rain) begin
          held_next  = ST_GAP;
          state_next = ST_HOLD;
        end else
`endif
        if (gap_reg <= GAP_W'(1)) begin
          if (found) begin
            state_next = ST_RUN;
            zone_next  = found_idx;
            timer_next = found_dur;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end

`ifdef RAIN_SENSE_EN
      ST_HOLD: begin
        if (!rain) state_next = held_reg;
      end
`endif

      default: state_next = ST_IDLE;
    endcase

    // Abort has priority over everything, including a natural finish.
    if (!en || stop) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
    end

    if (state_next == ST_RUN) begin
      dec_en  = 1'b1;
      dec_idx = zone_next;
    end else if (manual_hit) begin
      dec_en  = 1'b1;
      dec_idx = manual_zone;
    end
  end

  zone_decoder #(
    .NUM_ZONES(NUM_ZONES)
  ) u_zone_decoder (
    .idx   (dec_idx),
    .en    (dec_en),
    .onehot(dec_onehot)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      zone_reg    <= '0;
      timer_reg   <= '0;
      gap_reg     <= '0;
      valve       <= '0;
      active_zone <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef RAIN_SENSE_EN
      held_reg    <= ST_IDLE;
`endif
    end else begin
      state_reg   <= state_next;
      zone_reg    <= zone_next;
      timer_reg   <= timer_next;
      gap_reg     <= gap_next;
      valve       <= dec_onehot;
      active_zone <= (state_next == ST_RUN) ? zone_next : '0;
      busy        <= (state_next != ST_IDLE);
      done        <= done_next;
`ifdef RAIN_SENSE_EN
      held_reg    <= held_next;
`endif
    end
  end

endmodule

// File: tb/tb_sprinkler_zone_sequencer.sv
// Directed bench for sprinkler_zone_sequencer (8 zones, GAP_CYCLES=2).
// Compile with RAIN_SENSE_EN defined to also exercise the rain hold.
module tb_sprinkler_zone_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, start, stop, manual_mode, cfg_we;
  logic [2:0] manual_zone, cfg_zone;
  logic [7:0] cfg_dur;
  logic [7:0] valve;
  logic [2:0] active_zone;
  logic       busy, done;
`ifdef RAIN_SENSE_EN
  logic       rain;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [7:0] dur_arr_t [8];

  typedef struct {
    logic       en;
    logic       start;
    logic       stop;
    logic       mm;
    logic [2:0] mz;
    logic [7:0] exp_valve;
    logic       exp_busy;
    logic [2:0] exp_act;
  } vec_t;

  vec_t vecs [13];

  sprinkler_zone_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .manual_mode(manual_mode),
    .manual_zone(manual_zone),
    .cfg_we     (cfg_we),
    .cfg_zone   (cfg_zone),
    .cfg_dur    (cfg_dur),
    .valve      (valve),
    .active_zone(active_zone),
    .busy       (busy),
    .done       (done)
`ifdef RAIN_SENSE_EN
    ,
    .rain       (rain)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic write_dur(input logic [2:0] z, input logic [7:0] d);
    cfg_we = 1'b1; cfg_zone = z; cfg_dur = d;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic load_table(input dur_arr_t d);
    for (int z = 0; z < 8; z++) write_dur(3'(z), d[z]);
  endtask

  // Expected waveform of a complete automatic cycle built from the duration list.
  task automatic run_auto(input dur_arr_t d, input string tag);
    int on_cnt [8];
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int z = 0; z < 8; z++) begin
      on_cnt[z] = 0;
      if (d[z] != 8'd0) begin
        for (int k = 0; k < int'(d[z]); k++) begin
          check({tag, "_valve_on"}, valve, 64'(8'h01 << z));
          check({tag, "_active"}, active_zone, 64'(z));
          check({tag, "_busy_run"}, busy, 1);
          check({tag, "_done_run"}, done, 0);
          if (valve == (8'h01 << z)) on_cnt[z]++;
          tick;
        end
        for (int g = 0; g < 2; g++) begin
          check({tag, "_valve_gap"}, valve, 0);
          check({tag, "_busy_gap"}, busy, 1);
          tick;
        end
      end
    end
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valve_end"}, valve, 0);
    tick;
    check({tag, "_done_once"}, done, 0);
    for (int z = 0; z < 8; z++)
      $display("%s zone %0d on for %0d cycles", tag, z, on_cnt[z]);
  endtask

  initial begin
    dur_arr_t d_full, d_skip, d_abort;
    d_full  = '{8'd3, 8'd1, 8'd2, 8'd4, 8'd1, 8'd2, 8'd3, 8'd1};
    d_skip  = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    d_abort = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd4, 8'd2, 8'd2, 8'd2};

    //             en    start stop  mm    mz     valve  busy  act
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0, 3'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 3'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 3'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 3'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0, 3'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0};

    rst_n = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; manual_mode = 1'b0;
    manual_zone = 3'd0; cfg_we = 1'b0; cfg_zone = 3'd0; cfg_dur = 8'd0;
`ifdef RAIN_SENSE_EN
    rain = 1'b0;
`endif

    // Reset state
    tick; tick;
    check("rst_valve", valve, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_active", active_zone, 0);
    rst_n = 1'b1;

    // Reset in the middle of RUN clears outputs and the table
    write_dur(3'd0, 8'd3);
    start = 1'b1; tick; start = 1'b0;
    check("midrun_valve_on", valve, 8'h01);
    rst_n = 1'b0; tick; tick;
    check("midrun_rst_valve", valve, 0);
    check("midrun_rst_busy", busy, 0);
    rst_n = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    check("table_cleared_busy", busy, 0);
    check("table_cleared_valve", valve, 0);
    tick;
    check("table_cleared_busy2", busy, 0);
    $display("reset phase complete");

    // Full cycle, then skipped zones
    load_table(d_full);
    run_auto(d_full, "full");
    load_table(d_skip);
    run_auto(d_skip, "skip");

    // Abort two cycles into zone 4
    load_table(d_abort);
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 100 && valve !== 8'h10; k++) tick;
    check("abort_reach_zone4", valve, 8'h10);
    check("abort_active4", active_zone, 4);
    tick;
    check("abort_zone4_2nd", valve, 8'h10);
    stop = 1'b1; tick; stop = 1'b0;
    check("abort_valve", valve, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int k = 0; k < 6; k++) begin
      tick;
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_valve", valve, 0);
    tick;
    check("start_stop_busy2", busy, 0);
    $display("abort phase complete");

    // Manual mode and start-while-busy, table driven
    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; start = vecs[i].start; stop = vecs[i].stop;
      manual_mode = vecs[i].mm; manual_zone = vecs[i].mz;
      tick;
      check($sformatf("vec%0d_valve", i), valve, vecs[i].exp_valve);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_active", i), active_zone, vecs[i].exp_act);
      $display("vec %0d: en=%b start=%b stop=%b mm=%b mz=%0d -> valve=%b busy=%b",
               i, en, start, stop, manual_mode, manual_zone, valve, busy);
    end
    start = 1'b0; stop = 1'b0; manual_mode = 1'b0; en = 1'b1;
    tick;

`ifdef RAIN_SENSE_EN
    // Rain hold: zone 0 paused after 2 of 5 cycles, resumes for 3, zone 1 follows
    load_table('{8'd5, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    start = 1'b1; tick; start = 1'b0;
    check("rain_on1", valve, 8'h01);
    tick;
    check("rain_on2", valve, 8'h01);
    rain = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("rain_hold_valve", valve, 0);
      check("rain_hold_busy", busy, 1);
    end
    rain = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("rain_resume_on", valve, 8'h01);
    end
    tick;
    check("rain_gap1", valve, 0);
    tick;
    check("rain_gap2", valve, 0);
    tick;
    check("rain_zone1", valve, 8'h02);
    check("rain_zone1_act", active_zone, 1);
    stop = 1'b1; tick; stop = 1'b0;
    rain = 1'b1; manual_mode = 1'b1; manual_zone = 3'd3; tick;
    check("rain_blocks_manual", valve, 0);
    manual_mode = 1'b0; start = 1'b1; tick; start = 1'b0;
    check("rain_blocks_start", busy, 0);
    rain = 1'b0;
    $display("rain phase complete");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
